// File: rtl/msk_skinny_dec_fsm_pkg.sv
// msk_skinny_pkg: shared state type and round-constant
// helpers for the masked Skinny-128-256 controllers.
package msk_skinny_pkg;

  localparam int ROUNDS_DEFAULT = 40;
  localparam int SB_LAT_DEFAULT = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_KEY_FWD,
    S_ROUND,
    S_DONE
  } dec_state_t;

  function automatic logic [5:0] rc_fwd(
    input logic [5:0] rc
  );
    return {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};
  endfunction

  // Exact inverse of rc_fwd: recovers the bit
  // that was shifted out of rc[5].
  function automatic logic [5:0] rc_bwd(
    input logic [5:0] rc
  );
    return {rc[0] ^ rc[5] ^ 1'b1, rc[5:1]};
  endfunction

endpackage

// File: rtl/msk_skinny_dec_fsm_if.sv
// msk_skinny_dec_fsm_if: start/status and datapath
// strobe bundle between controller and datapath.
interface msk_skinny_dec_fsm_if
  import msk_skinny_pkg::*;
#(
  parameter int SB_LAT = SB_LAT_DEFAULT
);

  logic              start;
  logic              busy;
  logic              done;
  logic              ld;
  logic              tk_fwd_en;
  logic              tk_bwd_en;
  logic              lin_en;
  logic [SB_LAT-1:0] sb_en;
  logic              sb_wb;
  logic              rnd_req;
  logic [5:0]        rc;

  modport master (
    input  start,
    output busy, done, ld,
    output tk_fwd_en, tk_bwd_en,
    output lin_en, sb_en, sb_wb,
    output rnd_req, rc
  );

  modport slave (
    output start,
    input  busy, done, ld,
    input  tk_fwd_en, tk_bwd_en,
    input  lin_en, sb_en, sb_wb,
    input  rnd_req, rc
  );

endinterface

// File: rtl/msk_skinny_dec_fsm_rc_lfsr.sv
// skinny_rc_lfsr: 6-bit bidirectional round-constant
// LFSR, one forward or backward step per cycle.
module skinny_rc_lfsr
  import msk_skinny_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_clr,
  input  logic       i_fwd,
  input  logic       i_bwd,
  output logic [5:0] o_rc
);

  logic [5:0] r_rc;

  // clear wins, then forward, then backward
  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_rc <= '0;
    end else if (i_fwd) begin
      r_rc <= rc_fwd(r_rc);
    end else if (i_bwd) begin
      r_rc <= rc_bwd(r_rc);
    end
  end

  assign o_rc = r_rc;

endmodule

// File: rtl/msk_skinny_dec_fsm.sv
// msk_skinny_dec_fsm: decryption sequencer driving the
// shared masked datapath (load, key ffwd, inverse rounds).
module msk_skinny_dec_fsm
  import msk_skinny_pkg::*;
#(
  parameter int ROUNDS = ROUNDS_DEFAULT,
  parameter int SB_LAT = SB_LAT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  msk_skinny_dec_fsm_if.master  bus
);

  localparam int RW = $clog2(ROUNDS + 1);
  localparam int CW = $clog2(SB_LAT + 2);
  localparam logic [RW-1:0] RND_LAST = RW'(ROUNDS - 1);
  localparam logic [CW-1:0] CYC_WB   = CW'(SB_LAT + 1);
  localparam logic [CW-1:0] CYC_SB_N = CW'(SB_LAT);

  dec_state_t r_state;
  dec_state_t w_state_nxt;

  logic [RW-1:0] r_round_cnt;
  logic [CW-1:0] r_cyc_cnt;

  logic w_last_rnd;
  logic w_cyc_lin;
  logic w_cyc_sb;
  logic w_cyc_wb;

  logic              w_busy;
  logic              w_done;
  logic              w_ld;
  logic              w_fwd;
  logic              w_bwd;
  logic              w_lin;
  logic [SB_LAT-1:0] w_sb;
  logic              w_wb;
  logic              w_rnd;
  logic [5:0]        w_rc;

  assign w_last_rnd = (r_round_cnt == RND_LAST);
  assign w_cyc_lin  = (r_cyc_cnt == '0);
  assign w_cyc_wb   = (r_cyc_cnt == CYC_WB);
  assign w_cyc_sb   = !w_cyc_lin
                   && (r_cyc_cnt <= CYC_SB_N);

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // next-state decode
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) w_state_nxt = S_KEY_FWD;
      end
      S_KEY_FWD: begin
        if (w_last_rnd) w_state_nxt = S_ROUND;
      end
      S_ROUND: begin
        if (w_cyc_wb && w_last_rnd)
          w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // round and in-round cycle counters
  always_ff @(posedge clk) begin
    if (reset) begin
      r_round_cnt <= '0;
      r_cyc_cnt   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_round_cnt <= '0;
            r_cyc_cnt   <= '0;
          end
        end
        S_KEY_FWD: begin
          r_round_cnt <= w_last_rnd ? '0
                       : r_round_cnt + RW'(1);
        end
        S_ROUND: begin
          if (w_cyc_wb) begin
            r_round_cnt <= r_round_cnt + RW'(1);
            r_cyc_cnt   <= '0;
          end else begin
            r_cyc_cnt <= r_cyc_cnt + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // strobe decode; ld is the only start-driven output
  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    w_ld   = 1'b0;
    w_fwd  = 1'b0;
    w_bwd  = 1'b0;
    w_lin  = 1'b0;
    w_sb   = '0;
    w_wb   = 1'b0;
    w_rnd  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_ld = bus.start & ~reset;
      end
      S_KEY_FWD: begin
        w_busy = 1'b1;
        w_fwd  = 1'b1;
      end
      S_ROUND: begin
        w_busy = 1'b1;
        w_lin  = w_cyc_lin;
        w_bwd  = w_cyc_lin;
        w_rnd  = w_cyc_sb;
        w_wb   = w_cyc_wb;
        if (w_cyc_sb)
          w_sb = SB_LAT'(1) << (r_cyc_cnt - CW'(1));
      end
      S_DONE: begin
        w_done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  skinny_rc_lfsr u_rc (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_ld),
    .i_fwd (w_fwd),
    .i_bwd (w_bwd),
    .o_rc  (w_rc)
  );

  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
  assign bus.ld        = w_ld;
  assign bus.tk_fwd_en = w_fwd;
  assign bus.tk_bwd_en = w_bwd;
  assign bus.lin_en    = w_lin;
  assign bus.sb_en     = w_sb;
  assign bus.sb_wb     = w_wb;
  assign bus.rnd_req   = w_rnd;
  assign bus.rc        = w_rc;

endmodule

// File: tb/tb_msk_skinny_dec_fsm.sv
// tb_msk_skinny_dec_fsm: scoreboard bench for the masked
// Skinny decryption controller (default and tiny configs).
module tb_msk_skinny_dec_fsm;
  import msk_skinny_pkg::*;

  localparam int R1 = 40;
  localparam int L1 = 4;
  localparam int R2 = 2;
  localparam int L2 = 1;

  localparam int K_LD   = 0;
  localparam int K_FWD  = 1;
  localparam int K_LIN  = 2;
  localparam int K_SB   = 3;
  localparam int K_WB   = 4;
  localparam int K_DONE = 5;

  typedef struct {
    int         t;
    int         kind;
    logic [5:0] val;
  } ev_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  ev_t  q[$];

  // encryption round constants, round 0..39
  logic [5:0] enc_rc [40] = '{
    6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F,
    6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F,
    6'h1E, 6'h3C, 6'h39, 6'h33, 6'h27,
    6'h0E, 6'h1D, 6'h3A, 6'h35, 6'h2B,
    6'h16, 6'h2C, 6'h18, 6'h30, 6'h21,
    6'h02, 6'h05, 6'h0B, 6'h17, 6'h2E,
    6'h1C, 6'h38, 6'h31, 6'h23, 6'h06,
    6'h0D, 6'h1B, 6'h36, 6'h2D, 6'h1A
  };

  always #5 clk = ~clk;

  msk_skinny_dec_fsm_if #(.SB_LAT(L1)) bus1 ();
  msk_skinny_dec_fsm_if #(.SB_LAT(L2)) bus2 ();

  msk_skinny_dec_fsm #(.ROUNDS(R1), .SB_LAT(L1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  msk_skinny_dec_fsm #(.ROUNDS(R2), .SB_LAT(L2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  function automatic ev_t decode(
    int t, logic ld, logic fwd, logic lin,
    logic [3:0] sb, logic wb, logic dn,
    logic [5:0] rc
  );
    ev_t e;
    e.t = t;
    e.kind = -1;
    e.val = '0;
    if (ld) e.kind = K_LD;
    else if (fwd) e.kind = K_FWD;
    else if (lin) begin
      e.kind = K_LIN;
      e.val = rc;
    end else if (sb != 4'd0) begin
      e.kind = K_SB;
      e.val = {2'b00, sb};
    end else if (wb) e.kind = K_WB;
    else if (dn) begin
      e.kind = K_DONE;
      e.val = rc;
    end
    return e;
  endfunction

  function automatic ev_t obs1(int t);
    return decode(t, bus1.ld, bus1.tk_fwd_en,
      bus1.lin_en, bus1.sb_en, bus1.sb_wb,
      bus1.done, bus1.rc);
  endfunction

  function automatic ev_t obs2(int t);
    return decode(t, bus2.ld, bus2.tk_fwd_en,
      bus2.lin_en, {3'b000, bus2.sb_en},
      bus2.sb_wb, bus2.done, bus2.rc);
  endfunction

  function automatic logic [17:0] outs1();
    return {bus1.busy, bus1.done, bus1.ld,
      bus1.tk_fwd_en, bus1.tk_bwd_en,
      bus1.lin_en, bus1.sb_en, bus1.sb_wb,
      bus1.rnd_req, bus1.rc};
  endfunction

  function automatic logic [17:0] outs2();
    return {bus2.busy, bus2.done, bus2.ld,
      bus2.tk_fwd_en, bus2.tk_bwd_en,
      bus2.lin_en, 3'b000, bus2.sb_en,
      bus2.sb_wb, bus2.rnd_req, bus2.rc};
  endfunction

  function automatic void push_ev(
    int t, int k, logic [5:0] v, int tmax
  );
    ev_t e;
    if (t > tmax) return;
    e.t = t;
    e.kind = k;
    e.val = v;
    q.push_back(e);
  endfunction

  // expected strobe trace of one decryption from t0
  function automatic void push_run(
    int t0, int nr, int nl, int tmax
  );
    push_ev(t0, K_LD, 6'd0, tmax);
    for (int i = 1; i <= nr; i++)
      push_ev(t0 + i, K_FWD, 6'd0, tmax);
    for (int r = 0; r < nr; r++) begin
      int ts;
      ts = t0 + 1 + nr + r * (nl + 2);
      push_ev(ts, K_LIN, enc_rc[nr-1-r], tmax);
      for (int k = 1; k <= nl; k++)
        push_ev(ts + k, K_SB, 6'(1 << (k - 1)), tmax);
      push_ev(ts + nl + 1, K_WB, 6'd0, tmax);
    end
    push_ev(t0 + 1 + nr * (nl + 3), K_DONE, 6'd0, tmax);
  endfunction

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    bus1.start = 1'b0;
    bus2.start = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus1.start = 1'b0;
    bus2.start = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (outs1() !== 18'd0) begin
      errors++;
      $display("FAIL reset_out1 got=%h exp=0", outs1());
    end
    checks++;
    if (outs2() !== 18'd0) begin
      errors++;
      $display("FAIL reset_out2 got=%h exp=0", outs2());
    end
    checks++;
    if (dut1.r_state !== S_IDLE) begin
      errors++;
      $display("FAIL reset_state got=%0d exp=%0d",
        dut1.r_state, S_IDLE);
    end
    checks++;
    if (dut1.r_round_cnt !== '0
        || dut1.r_cyc_cnt !== '0) begin
      errors++;
      $display("FAIL reset_cnt got=%0d/%0d exp=0/0",
        dut1.r_round_cnt, dut1.r_cyc_cnt);
    end
  endtask

  task automatic test_nominal();
    ev_t e, x;
    int busy_n;
    busy_n = 0;
    q.delete();
    push_run(0, R1, L1, 100000);
    for (int t = 0; t <= 285; t++) begin
      @(posedge clk);
      #1 bus1.start = (t == 0);
      @(negedge clk);
      if (bus1.busy === 1'b1) busy_n++;
      if (t == 0 || t == 281) begin
        checks++;
        if (bus1.busy !== 1'b0) begin
          errors++;
          $display("FAIL nom_busy_edge t=%0d got=%b exp=0",
            t, bus1.busy);
        end
      end
      e = obs1(t);
      if (e.kind >= 0) begin
        checks++;
        x.t = -1; x.kind = -1; x.val = '0;
        if (q.size() > 0) x = q.pop_front();
        if (e.t !== x.t || e.kind !== x.kind
            || e.val !== x.val) begin
          errors++;
          $display("FAIL nom_ev got t=%0d k=%0d v=%h exp t=%0d k=%0d v=%h",
            e.t, e.kind, e.val, x.t, x.kind, x.val);
        end
      end
    end
    checks++;
    if (busy_n != R1 * (L1 + 3)) begin
      errors++;
      $display("FAIL nom_busy_cnt got=%0d exp=%0d",
        busy_n, R1 * (L1 + 3));
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL nom_missing got=%0d left exp=0",
        q.size());
    end
  endtask

  task automatic test_start_held();
    ev_t e, x;
    int done_n;
    done_n = 0;
    do_reset();
    q.delete();
    push_run(0, R1, L1, 100000);
    push_ev(282, K_LD, 6'd0, 100000);
    for (int t = 0; t <= 282; t++) begin
      @(posedge clk);
      #1 bus1.start = 1'b1;
      @(negedge clk);
      if (bus1.done === 1'b1) done_n++;
      e = obs1(t);
      if (e.kind >= 0) begin
        checks++;
        x.t = -1; x.kind = -1; x.val = '0;
        if (q.size() > 0) x = q.pop_front();
        if (e.t !== x.t || e.kind !== x.kind
            || e.val !== x.val) begin
          errors++;
          $display("FAIL held_ev got t=%0d k=%0d v=%h exp t=%0d k=%0d v=%h",
            e.t, e.kind, e.val, x.t, x.kind, x.val);
        end
      end
    end
    checks++;
    if (done_n != 1) begin
      errors++;
      $display("FAIL held_done_cnt got=%0d exp=1", done_n);
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL held_missing got=%0d left exp=0",
        q.size());
    end
  endtask

  task automatic test_reset_mid();
    ev_t e, x;
    do_reset();
    q.delete();
    push_run(0, R1, L1, 100);
    push_run(105, R1, L1, 100000);
    for (int t = 0; t <= 390; t++) begin
      @(posedge clk);
      #1 bus1.start = (t == 0 || t == 105);
      reset = (t == 100);
      @(negedge clk);
      if (t == 101) begin
        checks++;
        if (outs1() !== 18'd0
            || dut1.r_state !== S_IDLE) begin
          errors++;
          $display("FAIL mid_reset got=%h st=%0d exp=0 st=%0d",
            outs1(), dut1.r_state, S_IDLE);
        end
      end
      e = obs1(t);
      if (e.kind >= 0) begin
        checks++;
        x.t = -1; x.kind = -1; x.val = '0;
        if (q.size() > 0) x = q.pop_front();
        if (e.t !== x.t || e.kind !== x.kind
            || e.val !== x.val) begin
          errors++;
          $display("FAIL mid_ev got t=%0d k=%0d v=%h exp t=%0d k=%0d v=%h",
            e.t, e.kind, e.val, x.t, x.kind, x.val);
        end
      end
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL mid_missing got=%0d left exp=0",
        q.size());
    end
  endtask

  task automatic test_small();
    ev_t e, x;
    do_reset();
    q.delete();
    push_run(0, R2, L2, 100000);
    for (int t = 0; t <= 12; t++) begin
      @(posedge clk);
      #1 bus2.start = (t == 0);
      @(negedge clk);
      e = obs2(t);
      if (e.kind >= 0) begin
        checks++;
        x.t = -1; x.kind = -1; x.val = '0;
        if (q.size() > 0) x = q.pop_front();
        if (e.t !== x.t || e.kind !== x.kind
            || e.val !== x.val) begin
          errors++;
          $display("FAIL small_ev got t=%0d k=%0d v=%h exp t=%0d k=%0d v=%h",
            e.t, e.kind, e.val, x.t, x.kind, x.val);
        end
      end
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL small_missing got=%0d left exp=0",
        q.size());
    end
  endtask

  task automatic test_random();
    int grp;
    int rnd_n;
    rnd_n = 0;
    do_reset();
    for (int t = 0; t < 4000; t++) begin
      @(posedge clk);
      #1 reset = ($urandom_range(0, 599) == 0);
      bus1.start = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      grp = int'(bus1.ld) + int'(bus1.tk_fwd_en)
          + int'(bus1.lin_en) + int'(bus1.sb_en != 0)
          + int'(bus1.sb_wb) + int'(bus1.done);
      checks++;
      if (grp > 1 || !$onehot0(bus1.sb_en)
          || bus1.tk_bwd_en !== bus1.lin_en
          || bus1.rnd_req !== (bus1.sb_en != 0)) begin
        errors++;
        $display("FAIL rand_excl t=%0d got=%h exp=exclusive",
          t, outs1());
      end
      if (bus1.ld === 1'b1) rnd_n = 0;
      if (bus1.rnd_req === 1'b1) rnd_n++;
      if (bus1.done === 1'b1) begin
        checks++;
        if (rnd_n != 4 * R1) begin
          errors++;
          $display("FAIL rand_rnd_cnt got=%0d exp=%0d",
            rnd_n, 4 * R1);
        end
      end
    end
  endtask

  initial begin
    bus1.start = 1'b0;
    bus2.start = 1'b0;
    test_reset();
    test_nominal();
    test_start_held();
    test_reset_mid();
    test_small();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
